// File: rtl/status_drain_packer.sv
// status_drain_packer
//   Pulls the oldest bit from the status value vector whenever it reports a
//   valid entry. Bits are packed LSB-first into BEAT_W-bit words and presented
//   on a valid/ready master port through one registered output slot.
//   Saturating counters record how many ones and zeros were pulled.
//   Partial words leave only on a flush request.
//   Optional feature macro: STATUS_DRAIN_TIMEOUT_EN. When it is defined, an
//   accumulator that stays idle for TIMEOUT cycles is flushed automatically.
module status_drain_packer #(
  parameter int BEAT_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sv_valid_i,
  input  logic                         sv_value_i,
  output logic                         sv_pull_o,
  input  logic                         flush_i,
  input  logic                         m_ready_i,
  output logic                         m_valid_o,
  output logic [BEAT_W-1:0]            m_data_o,
  output logic [$clog2(BEAT_W+1)-1:0]  m_count_o,
  output logic [CNT_W-1:0]             ones_cnt_o,
  output logic [CNT_W-1:0]             zeros_cnt_o,
  output logic                         busy_o
);

  localparam int                IDX_W    = $clog2(BEAT_W + 1);
  localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(BEAT_W);
  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Reject parameter values that the datapath cannot represent.
  if (BEAT_W < 2 || BEAT_W > 32) begin : g_bad_beat_w
    $error("status_drain_packer: BEAT_W must be within 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("status_drain_packer: CNT_W must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("status_drain_packer: TIMEOUT must be at least 1");
  end

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_r, state_s;
  logic [BEAT_W-1:0]   acc_r, acc_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [BEAT_W-1:0]   data_r, data_s;
  logic [IDX_W-1:0]    count_r, count_s;
  logic                valid_r, valid_s;
  logic [CNT_W-1:0]    ones_r, ones_s;
  logic [CNT_W-1:0]    zeros_r, zeros_s;
  logic                busy_r;

  logic                slot_free_s;
  logic                full_s;
  logic                xfer_s;
  logic                pull_s;
  logic                flush_req_s;
  logic                timeout_hit_s;
  logic [BEAT_W-1:0]   acc_base_s;
  logic [IDX_W-1:0]    idx_base_s;
  logic [BEAT_W-1:0]   bit_s;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      return cnt;
    end else begin
      return cnt + CNT_ONE;
    end
  endfunction

  // Slot handshake, word transfer and pull decision.
  always_comb begin
    slot_free_s = ~valid_r | m_ready_i;
    full_s      = (idx_r == IDX_FULL);
    xfer_s      = slot_free_s & (full_s | ((state_r == ST_FLUSH) & (idx_r != IDX_ZERO)));
    pull_s      = ~rst_i & sv_valid_i & (state_r == ST_RUN) & (~full_s | xfer_s);
  end

  assign sv_pull_o = pull_s;

`ifdef STATUS_DRAIN_TIMEOUT_EN
  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] idle_r, idle_s;
  logic            idle_cyc_s;

  // Idle tracking: RUN cycles with a non-empty accumulator and no pull.
  always_comb begin
    idle_cyc_s    = (state_r == ST_RUN) & (idx_r != IDX_ZERO) & ~pull_s;
    timeout_hit_s = idle_cyc_s & (idle_r == TO_LAST);
    if (idle_cyc_s && !timeout_hit_s) begin
      idle_s = idle_r + TO_W'(1);
    end else begin
      idle_s = {TO_W{1'b0}};
    end
  end

  // Idle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_r <= {TO_W{1'b0}};
    end else begin
      idle_r <= idle_s;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Accumulator, output slot and counter next-state values.
  always_comb begin
    bit_s = {{(BEAT_W-1){1'b0}}, sv_value_i};

    // A transfer empties the accumulator; a simultaneous pull restarts at bit 0.
    if (xfer_s) begin
      acc_base_s = {BEAT_W{1'b0}};
      idx_base_s = IDX_ZERO;
    end else begin
      acc_base_s = acc_r;
      idx_base_s = idx_r;
    end

    if (pull_s) begin
      acc_s = acc_base_s | (bit_s << idx_base_s);
      idx_s = idx_base_s + IDX_ONE;
    end else begin
      acc_s = acc_base_s;
      idx_s = idx_base_s;
    end

    if (xfer_s) begin
      data_s  = acc_r;
      count_s = idx_r;
      valid_s = 1'b1;
    end else if (valid_r && m_ready_i) begin
      data_s  = data_r;
      count_s = count_r;
      valid_s = 1'b0;
    end else begin
      data_s  = data_r;
      count_s = count_r;
      valid_s = valid_r;
    end

    if (pull_s && sv_value_i) begin
      ones_s  = sat_inc(ones_r);
      zeros_s = zeros_r;
    end else if (pull_s) begin
      ones_s  = ones_r;
      zeros_s = sat_inc(zeros_r);
    end else begin
      ones_s  = ones_r;
      zeros_s = zeros_r;
    end
  end

  // RUN/FLUSH state machine. A flush only takes effect if bits remain to emit.
  always_comb begin
    flush_req_s = flush_i | timeout_hit_s;
    state_s     = state_r;
    case (state_r)
      ST_RUN: begin
        if (flush_req_s && (idx_s != IDX_ZERO)) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (xfer_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State register; reset discards all pending bits and statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_RUN;
      acc_r   <= {BEAT_W{1'b0}};
      idx_r   <= IDX_ZERO;
      data_r  <= {BEAT_W{1'b0}};
      count_r <= IDX_ZERO;
      valid_r <= 1'b0;
      ones_r  <= {CNT_W{1'b0}};
      zeros_r <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      count_r <= count_s;
      valid_r <= valid_s;
      ones_r  <= ones_s;
      zeros_r <= zeros_s;
      busy_r  <= valid_s | (idx_s != IDX_ZERO);
    end
  end

  assign m_valid_o   = valid_r;
  assign m_data_o    = data_r;
  assign m_count_o   = count_r;
  assign ones_cnt_o  = ones_r;
  assign zeros_cnt_o = zeros_r;
  assign busy_o      = busy_r;

endmodule
